// File: rtl/step_dir_generator.sv
// rtl/step_dir_generator.sv - queued step/dir pulse generator with dir setup, pulse width and position tracking
module step_dir_generator #(
    parameter int STEPS_W  = 16,
    parameter int PERIOD_W = 24,
    parameter int POS_W    = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_dir,
    input  logic [STEPS_W-1:0]  cmd_steps,
    input  logic [PERIOD_W-1:0] cmd_period,
    input  logic [7:0]          config_pulse_width,
    input  logic [7:0]          config_dir_setup,
    input  logic                abort,
    output logic                step,
    output logic                dir,
    output logic                busy,
    output logic                done,
    output logic                aborted,
    output logic [STEPS_W-1:0]  steps_remaining,
    output logic [POS_W-1:0]    position
);
    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_HIGH, ST_LOW} state_t;

    localparam logic [PERIOD_W-1:0] P_ONE = PERIOD_W'(1);
    localparam logic [PERIOD_W-1:0] P_TWO = PERIOD_W'(2);
    localparam logic [STEPS_W-1:0]  S_ONE = STEPS_W'(1);
    localparam logic [POS_W-1:0]    X_ONE = POS_W'(1);

    state_t                state_q, state_d;
    logic                  dir_q, dir_d, step_q, step_d, done_q, done_d, aborted_q, aborted_d;
    logic                  abt_q, abt_d;
    logic [STEPS_W-1:0]    rem_q, rem_d;
    logic [POS_W-1:0]      pos_q, pos_d;
    logic [PERIOD_W-1:0]   pcnt_q, pcnt_d, per_q, per_d, act_period_q, act_period_d;
    logic [7:0]            pw_q, pw_d;
    logic                  pend_valid_q, pend_valid_d, pend_dir_q, pend_dir_d;
    logic [STEPS_W-1:0]    pend_steps_q, pend_steps_d;
    logic [PERIOD_W-1:0]   pend_period_q, pend_period_d;

    logic [7:0]            pw_eff, su_eff;
    logic [PERIOD_W-1:0]   pw_ext, pw_plus1, hi_period;
    logic                  load, go_high, end_abort, last_low;

    assign pw_eff   = (config_pulse_width == 8'd0) ? 8'd1 : config_pulse_width;
    assign su_eff   = (config_dir_setup == 8'd0) ? 8'd1 : config_dir_setup;
    assign pw_ext   = {{(PERIOD_W-8){1'b0}}, pw_q};
    assign pw_plus1 = {{(PERIOD_W-8){1'b0}}, pw_eff} + P_ONE;

    assign cmd_ready       = !pend_valid_q && !abort;
    assign step            = step_q;
    assign dir             = dir_q;
    assign done            = done_q;
    assign aborted         = aborted_q;
    assign busy            = (state_q != ST_IDLE) || aborted_q;
    assign steps_remaining = rem_q;
    assign position        = pos_q;

    always_comb begin
        state_d       = state_q;
        dir_d         = dir_q;
        step_d        = step_q;
        done_d        = 1'b0;
        aborted_d     = 1'b0;
        abt_d         = abt_q;
        rem_d         = rem_q;
        pos_d         = pos_q;
        pcnt_d        = pcnt_q;
        per_d         = per_q;
        pw_d          = pw_q;
        act_period_d  = act_period_q;
        pend_valid_d  = pend_valid_q;
        pend_dir_d    = pend_dir_q;
        pend_steps_d  = pend_steps_q;
        pend_period_d = pend_period_q;
        load          = 1'b0;
        go_high       = 1'b0;
        end_abort     = 1'b0;
        hi_period     = act_period_q;
        last_low      = (pcnt_q == per_q - P_ONE);

        case (state_q)
            ST_IDLE: begin
                if (abort) end_abort = pend_valid_q;
                else       load      = pend_valid_q;
            end
            ST_SETUP: begin
                if (abort)                         end_abort = 1'b1;
                else if (pcnt_q == per_q - P_ONE)  go_high   = 1'b1;
                else                               pcnt_d    = pcnt_q + P_ONE;
            end
            ST_HIGH: begin
                // An abort seen mid-pulse is remembered so the pulse still completes its full width.
                pcnt_d = pcnt_q + P_ONE;
                abt_d  = abt_q | abort;
                if (pcnt_q == pw_ext - P_ONE) begin
                    step_d = 1'b0;
                    if (abt_q || abort) begin
                        end_abort = 1'b1;
                    end else begin
                        state_d = ST_LOW;
                        done_d  = (rem_q == '0) && (pcnt_q == per_q - P_TWO);
                    end
                end
            end
            ST_LOW: begin
                if (last_low && rem_q == '0) begin
                    if (abort)             state_d = ST_IDLE;
                    else if (pend_valid_q) load    = 1'b1;
                    else                   state_d = ST_IDLE;
                end else if (abort) begin
                    end_abort = 1'b1;
                end else if (last_low) begin
                    go_high = 1'b1;
                end else begin
                    pcnt_d = pcnt_q + P_ONE;
                    done_d = (rem_q == '0) && (pcnt_q == per_q - P_TWO);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (end_abort) begin
            state_d   = ST_IDLE;
            done_d    = 1'b1;
            aborted_d = 1'b1;
            abt_d     = 1'b0;
        end

        if (load) begin
            if (pend_steps_q == '0) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end else begin
                act_period_d = pend_period_q;
                hi_period    = pend_period_q;
                rem_d        = pend_steps_q;
                if (pend_dir_q == dir_q) begin
                    go_high = 1'b1;
                end else begin
                    state_d = ST_SETUP;
                    dir_d   = pend_dir_q;
                    pcnt_d  = '0;
                    per_d   = {{(PERIOD_W-8){1'b0}}, su_eff};
                end
            end
        end

        // Step rising edge: counts, position and the period for this step are all fixed here.
        if (go_high) begin
            state_d = ST_HIGH;
            step_d  = 1'b1;
            pcnt_d  = '0;
            pw_d    = pw_eff;
            per_d   = (hi_period > pw_plus1) ? hi_period : pw_plus1;
            rem_d   = rem_d - S_ONE;
            pos_d   = dir_d ? (pos_q + X_ONE) : (pos_q - X_ONE);
        end

        if (abort || load || end_abort) pend_valid_d = 1'b0;
        if (cmd_valid && cmd_ready) begin
            pend_valid_d  = 1'b1;
            pend_dir_d    = cmd_dir;
            pend_steps_d  = cmd_steps;
            pend_period_d = cmd_period;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            dir_q         <= 1'b0;
            step_q        <= 1'b0;
            done_q        <= 1'b0;
            aborted_q     <= 1'b0;
            abt_q         <= 1'b0;
            rem_q         <= '0;
            pos_q         <= '0;
            pcnt_q        <= '0;
            per_q         <= '0;
            pw_q          <= 8'd1;
            act_period_q  <= '0;
            pend_valid_q  <= 1'b0;
            pend_dir_q    <= 1'b0;
            pend_steps_q  <= '0;
            pend_period_q <= '0;
        end else begin
            state_q       <= state_d;
            dir_q         <= dir_d;
            step_q        <= step_d;
            done_q        <= done_d;
            aborted_q     <= aborted_d;
            abt_q         <= abt_d;
            rem_q         <= rem_d;
            pos_q         <= pos_d;
            pcnt_q        <= pcnt_d;
            per_q         <= per_d;
            pw_q          <= pw_d;
            act_period_q  <= act_period_d;
            pend_valid_q  <= pend_valid_d;
            pend_dir_q    <= pend_dir_d;
            pend_steps_q  <= pend_steps_d;
            pend_period_q <= pend_period_d;
        end
    end
endmodule

// File: tb/tb_step_dir_generator.sv
// tb/tb_step_dir_generator.sv - scoreboard bench for step_dir_generator (8-bit position to reach wrap quickly)
module tb_step_dir_generator;
    logic        clk = 1'b0, reset = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_dir = 1'b0, abort = 1'b0;
    logic [15:0] cmd_steps = '0;
    logic [23:0] cmd_period = '0;
    logic [7:0]  config_pulse_width = 8'd4, config_dir_setup = 8'd1;
    logic        step, dir, busy, done, aborted;
    logic [15:0] steps_remaining;
    logic [7:0]  position;

    step_dir_generator #(.STEPS_W(16), .PERIOD_W(24), .POS_W(8)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .cmd_period(cmd_period),
        .config_pulse_width(config_pulse_width), .config_dir_setup(config_dir_setup),
        .abort(abort), .step(step), .dir(dir), .busy(busy), .done(done), .aborted(aborted),
        .steps_remaining(steps_remaining), .position(position));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0, passed = 0, failed = 0;
    typedef struct { int c; logic [7:0] p; int w; } step_t;
    typedef struct { int c; logic ab; } done_t;
    step_t step_sb[$];
    done_t done_sb[$];
    step_t se;
    done_t de;
    logic [7:0] exp_pos = 8'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_steps(input int first, input int n, input int per, input int w, input bit d);
        for (int k = 0; k < n; k++) begin
            exp_pos = d ? exp_pos + 8'd1 : exp_pos - 8'd1;
            step_sb.push_back('{first + k * per, exp_pos, w});
        end
    endtask

    task automatic push_done(input int c, input logic ab);
        done_sb.push_back('{c, ab});
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic issue(input bit d, input int n, input int per, output int e1);
        int tmo = 0;
        while (!cmd_ready && tmo < 1000) begin
            @(negedge clk);
            tmo++;
        end
        check("issue_ready_timeout", tmo < 1000, 1);
        cmd_valid  = 1'b1;
        cmd_dir    = d;
        cmd_steps  = 16'(n);
        cmd_period = 24'(per);
        e1 = cyc + 2;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    logic step_prev = 1'b0;
    int   rise_c = 0, rise_w = 0;
    always @(negedge clk) begin
        if (reset) begin
            step_prev = 1'b0;
        end else begin
            if (step && !step_prev) begin
                total++;
                assert (step_sb.size() > 0) passed++;
                else begin
                    failed++;
                    $error("FAIL step_unexpected observed=cycle %0d expected=no step", cyc);
                end
                if (step_sb.size() > 0) begin
                    se = step_sb.pop_front();
                    check("step_cycle", cyc, se.c);
                    check("step_position", {24'd0, position}, {24'd0, se.p});
                    rise_w = se.w;
                end
                rise_c = cyc;
            end
            if (!step && step_prev) check("pulse_width", cyc - rise_c, rise_w);
            if (done) begin
                total++;
                assert (done_sb.size() > 0) passed++;
                else begin
                    failed++;
                    $error("FAIL done_unexpected observed=cycle %0d expected=no done", cyc);
                end
                if (done_sb.size() > 0) begin
                    de = done_sb.pop_front();
                    check("done_cycle", cyc, de.c);
                    check("done_aborted", aborted, de.ab);
                end
            end
            step_prev = step;
        end
    end

    initial begin
        int e1;
        repeat (3) @(negedge clk);
        check("rst_step", step, 0);
        check("rst_dir", dir, 0);
        check("rst_position", position, 0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_aborted", aborted, 0);
        check("rst_remaining", steps_remaining, 0);
        check("rst_ready", cmd_ready, 1);

        // Same dir: step at E1, 10 apart, 4 high, done 9 after last rise.
        config_pulse_width = 8'd4; config_dir_setup = 8'd1;
        push_steps(cyc + 2, 3, 10, 4, 1'b0);
        push_done(cyc + 2 + 29, 1'b0);
        issue(1'b0, 3, 10, e1);
        wait_cyc(e1);
        check("t1_busy", busy, 1);
        check("t1_remaining", steps_remaining, 2);
        wait_cyc(e1 + 30);
        check("t1_busy_end", busy, 0);
        check("t1_position", position, 8'hFD);

        // Direction change with setup of 5 cycles.
        config_pulse_width = 8'd2; config_dir_setup = 8'd5;
        push_steps(cyc + 2 + 5, 2, 8, 2, 1'b1);
        push_done(cyc + 2 + 20, 1'b0);
        issue(1'b1, 2, 8, e1);
        wait_cyc(e1);
        check("t2_dir", dir, 1);
        check("t2_step_low", step, 0);
        check("t2_remaining", steps_remaining, 2);
        wait_cyc(e1 + 21);
        check("t2_position", position, 8'hFF);

        // Period clamped to pw+1, then zero pulse width treated as one.
        config_pulse_width = 8'd4;
        push_steps(cyc + 2, 3, 5, 4, 1'b1);
        push_done(cyc + 2 + 14, 1'b0);
        issue(1'b1, 3, 2, e1);
        wait_cyc(e1 + 15);
        config_pulse_width = 8'd0;
        push_steps(cyc + 2, 2, 3, 1, 1'b1);
        push_done(cyc + 2 + 5, 1'b0);
        issue(1'b1, 2, 3, e1);
        wait_cyc(e1 + 6);
        check("t3_position", position, 8'h04);

        // Back-to-back commands with B held pending.
        config_pulse_width = 8'd2;
        e1 = cyc + 2;
        push_steps(e1, 5, 10, 2, 1'b1);
        push_done(e1 + 19, 1'b0);
        push_done(e1 + 49, 1'b0);
        cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_steps = 16'd2; cmd_period = 24'd10;
        @(negedge clk);
        cmd_steps = 16'd3;
        @(negedge clk);
        check("t4_ready_after_load", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("t4_ready_pending", cmd_ready, 0);
        wait_cyc(e1 + 25);
        check("t4_busy_between", busy, 1);
        wait_cyc(e1 + 50);
        check("t4_busy_end", busy, 0);
        check("t4_position", position, 8'h09);

        // Abort one cycle into a 6-cycle pulse, with a command pending.
        config_pulse_width = 8'd6; config_dir_setup = 8'd3;
        push_steps(cyc + 2 + 3, 1, 20, 6, 1'b0);
        push_done(cyc + 2 + 9, 1'b1);
        issue(1'b0, 3, 20, e1);
        wait_cyc(e1);
        cmd_valid = 1'b1; cmd_dir = 1'b0; cmd_steps = 16'd5; cmd_period = 24'd20;
        wait_cyc(e1 + 1);
        cmd_valid = 1'b0;
        wait_cyc(e1 + 4);
        abort = 1'b1;
        wait_cyc(e1 + 5);
        check("t5_ready_abort", cmd_ready, 0);
        check("t5_step_held", step, 1);
        wait_cyc(e1 + 6);
        abort = 1'b0;
        wait_cyc(e1 + 10);
        check("t5_busy_end", busy, 0);
        wait_cyc(e1 + 60);
        check("t5_flushed_position", position, 8'h08);

        // Abort during LOW.
        config_pulse_width = 8'd2; config_dir_setup = 8'd1;
        push_steps(cyc + 2 + 1, 1, 10, 2, 1'b1);
        push_done(cyc + 2 + 6, 1'b1);
        issue(1'b1, 4, 10, e1);
        wait_cyc(e1 + 5);
        abort = 1'b1;
        wait_cyc(e1 + 6);
        abort = 1'b0;
        check("t6_remaining", steps_remaining, 3);
        wait_cyc(e1 + 8);
        check("t6_busy_end", busy, 0);

        // Zero-step command: done only, no dir change.
        push_done(cyc + 2, 1'b0);
        issue(1'b0, 0, 5, e1);
        wait_cyc(e1);
        check("t7_dir", dir, 1);
        check("t7_busy", busy, 0);
        wait_cyc(e1 + 5);

        // Walk position through the positive limit.
        config_pulse_width = 8'd1;
        push_steps(cyc + 2, 119, 2, 1, 1'b1);
        push_done(cyc + 2 + 237, 1'b0);
        issue(1'b1, 119, 2, e1);
        wait_cyc(e1 + 238);
        check("t8_wrap_position", position, 8'h80);

        // Reset in the middle of a pulse.
        config_pulse_width = 8'd4;
        push_steps(cyc + 2, 1, 10, 4, 1'b1);
        issue(1'b1, 5, 10, e1);
        wait_cyc(e1 + 1);
        check("t9_step_before_reset", step, 1);
        reset = 1'b1;
        #1;
        check("t9_step_reset", step, 0);
        check("t9_position_reset", position, 0);
        check("t9_busy_reset", busy, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        check("step_sb_empty", step_sb.size(), 0);
        check("done_sb_empty", done_sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
